// File: rtl/rs_mdu_bank_pkg.sv
// Shared defaults for the MDU reservation station: operand, ROB tag, opgen and exception widths.
package rs_mdu_bank_pkg;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ROB_ADDR_W = 4;
  localparam int DEF_OPGEN_W    = 8;
  localparam int DEF_EXC_W      = 8;
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: older_q[j][i] set means entry j was written before entry i.
// Selects the oldest entry in the ready vector, one-hot, combinationally.
module rs_age_matrix
  import rs_mdu_bank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest_oh
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    oldest_oh = ready & ~blocked;
  end

  // Stale bits on invalid rows are harmless: invalid entries are never ready,
  // and a row is cleared when its slot is reallocated.
  always_comb begin
    older_d = older_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (free_oh[j]) older_d[j] = '0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (alloc_oh[a]) begin
        older_d[a] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != a) older_d[j][a] = 1'b1;
        end
      end
    end
    if (flush) older_d = '{default: '0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) older_q <= '{default: '0};
    else      older_q <= older_d;
  end

endmodule

// File: rtl/rs_mdu_bank.sv
// Multi-entry MDU reservation station: CDB snoop wakeup, oldest-ready issue, one-cycle flush.
// Define RS_MDU_CDB_BYPASS_EN to resolve dispatch operands against the same-cycle CDB.
module rs_mdu_bank
  import rs_mdu_bank_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CDB_N      = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROB_ADDR_W = DEF_ROB_ADDR_W,
  parameter int OPGEN_W    = DEF_OPGEN_W,
  parameter int EXC_W      = DEF_EXC_W,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROB_ADDR_W-1:0]       in_rob_addr,
  input  logic [EXC_W-1:0]            in_exc_type,
  input  logic [OPGEN_W-1:0]          in_opgen,
  input  logic                        in_is_ref_1,
  input  logic                        in_is_ref_2,
  input  logic [DATA_W-1:0]           in_data_1,
  input  logic [DATA_W-1:0]           in_data_2,
  input  logic [CDB_N-1:0]            cdb_en,
  input  logic [CDB_N*ROB_ADDR_W-1:0] cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]     cdb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROB_ADDR_W-1:0]       out_rob_addr,
  output logic [EXC_W-1:0]            out_exc_type,
  output logic [OPGEN_W-1:0]          out_opgen,
  output logic [DATA_W-1:0]           out_data_1,
  output logic [DATA_W-1:0]           out_data_2,
  output logic [CNT_W-1:0]            count
);

  logic [DEPTH-1:0]      vld_q, vld_d, ref1_q, ref1_d, ref2_q, ref2_d;
  logic [ROB_ADDR_W-1:0] rob_q [DEPTH];
  logic [ROB_ADDR_W-1:0] rob_d [DEPTH];
  logic [EXC_W-1:0]      exc_q [DEPTH];
  logic [EXC_W-1:0]      exc_d [DEPTH];
  logic [OPGEN_W-1:0]    opg_q [DEPTH];
  logic [OPGEN_W-1:0]    opg_d [DEPTH];
  logic [DATA_W-1:0]     d1_q  [DEPTH];
  logic [DATA_W-1:0]     d1_d  [DEPTH];
  logic [DATA_W-1:0]     d2_q  [DEPTH];
  logic [DATA_W-1:0]     d2_d  [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DEPTH-1:0]  free_oh, rdy, sel;
  logic              free_found, wr, iss;
  logic              in_r1, in_r2;
  logic [DATA_W-1:0] in_v1, in_v2;

  assign in_ready  = ~&vld_q;
  assign wr        = in_valid & in_ready;
  assign rdy       = vld_q & ~ref1_q & ~ref2_q;
  assign out_valid = |rdy;
  assign iss       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alloc_oh  (wr ? free_oh : '0),
    .free_oh   (iss ? sel : '0),
    .ready     (rdy),
    .oldest_oh (sel)
  );

  always_comb begin
    out_rob_addr = '0;
    out_exc_type = '0;
    out_opgen    = '0;
    out_data_1   = '0;
    out_data_2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        out_rob_addr = rob_q[i];
        out_exc_type = exc_q[i];
        out_opgen    = opg_q[i];
        out_data_1   = d1_q[i];
        out_data_2   = d2_q[i];
      end
    end
  end

  always_comb begin
    in_r1 = in_is_ref_1;
    in_r2 = in_is_ref_2;
    in_v1 = in_data_1;
    in_v2 = in_data_2;
`ifdef RS_MDU_CDB_BYPASS_EN
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (in_is_ref_1 && cdb_en[k] && cdb_tag[k*ROB_ADDR_W +: ROB_ADDR_W] == in_data_1[ROB_ADDR_W-1:0]) begin
        in_r1 = 1'b0;
        in_v1 = cdb_data[k*DATA_W +: DATA_W];
      end
      if (in_is_ref_2 && cdb_en[k] && cdb_tag[k*ROB_ADDR_W +: ROB_ADDR_W] == in_data_2[ROB_ADDR_W-1:0]) begin
        in_r2 = 1'b0;
        in_v2 = cdb_data[k*DATA_W +: DATA_W];
      end
    end
`endif
  end

  // Buses are scanned high to low so the lowest matching bus index wins.
  always_comb begin
    vld_d  = vld_q;
    ref1_d = ref1_q;
    ref2_d = ref2_q;
    rob_d  = rob_q;
    exc_d  = exc_q;
    opg_d  = opg_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = CDB_N - 1; k >= 0; k--) begin
        if (vld_q[i] && ref1_q[i] && cdb_en[k] && cdb_tag[k*ROB_ADDR_W +: ROB_ADDR_W] == d1_q[i][ROB_ADDR_W-1:0]) begin
          ref1_d[i] = 1'b0;
          d1_d[i]   = cdb_data[k*DATA_W +: DATA_W];
        end
        if (vld_q[i] && ref2_q[i] && cdb_en[k] && cdb_tag[k*ROB_ADDR_W +: ROB_ADDR_W] == d2_q[i][ROB_ADDR_W-1:0]) begin
          ref2_d[i] = 1'b0;
          d2_d[i]   = cdb_data[k*DATA_W +: DATA_W];
        end
      end
      if (iss && sel[i]) vld_d[i] = 1'b0;
      if (wr && free_oh[i]) begin
        vld_d[i]  = 1'b1;
        ref1_d[i] = in_r1;
        ref2_d[i] = in_r2;
        rob_d[i]  = in_rob_addr;
        exc_d[i]  = in_exc_type;
        opg_d[i]  = in_opgen;
        d1_d[i]   = in_v1;
        d2_d[i]   = in_v2;
      end
    end
    count_d = count_q + CNT_W'(wr) - CNT_W'(iss);
    if (flush) begin
      vld_d   = '0;
      ref1_d  = '0;
      ref2_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      ref1_q  <= '0;
      ref2_q  <= '0;
      rob_q   <= '{default: '0};
      exc_q   <= '{default: '0};
      opg_q   <= '{default: '0};
      d1_q    <= '{default: '0};
      d2_q    <= '{default: '0};
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      ref1_q  <= ref1_d;
      ref2_q  <= ref2_d;
      rob_q   <= rob_d;
      exc_q   <= exc_d;
      opg_q   <= opg_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/rs_mdu_bank.md
# rs_mdu_bank

Multi-entry reservation station for the multiply/divide unit, sitting between dispatch and the MDU. It is the parametrised successor of the single-line MDU station. It holds up to DEPTH in-flight MDU ops and snoops CDB_N common data buses per cycle to resolve operand references. Each cycle it issues the oldest entry whose operands are both resolved. Entries are freed on issue; a pipeline flush empties the bank in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries; ≥2, power of two not required
- CDB_N, 2: number of CDB broadcast ports snooped per cycle
- DATA_W, 32: operand width
- ROB_ADDR_W, 4: ROB tag width; a referenced operand holds its tag in bits [ROB_ADDR_W-1:0]
- OPGEN_W, 8 / EXC_W, 8: opgen and exception-type widths (defaults from shared package)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous invalidate-all
- in_valid / in_ready  in/out  1  dispatch handshake; in_ready = bank not full
- in_rob_addr, in_exc_type, in_opgen  in  ROB_ADDR_W/EXC_W/OPGEN_W  op fields
- in_is_ref_1, in_is_ref_2  in  1  operand is a ROB tag, not a value
- in_data_1, in_data_2  in  DATA_W  value or tag
- cdb_en  in  CDB_N  per-bus broadcast valid
- cdb_tag  in  CDB_N*ROB_ADDR_W  flattened tags, bus k at [k*ROB_ADDR_W +: ROB_ADDR_W]
- cdb_data  in  CDB_N*DATA_W  flattened results
- out_valid / out_ready  out/in  1  issue handshake to MDU
- out_rob_addr, out_exc_type, out_opgen, out_data_1, out_data_2  out  widths as above  issued entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry state: valid, rob_addr, exc_type, opgen, is_ref_1/2, data_1/2. Entry ready = valid & !is_ref_1 & !is_ref_2.
- Write: on in_valid & in_ready, the entry lands in the lowest-index free slot. Age order is recorded: the new entry is younger than all valid entries.
- Wakeup: for each valid entry and operand with is_ref set and any k with cdb_en[k] & cdb_tag[k] == data[ROB_ADDR_W-1:0], load cdb_data[k] and clear is_ref. Two buses matching the same tag cannot occur (ROB guarantees this); if they do, the lowest k wins.
- Issue: out_valid = any ready entry. The out_* fields show the oldest ready entry, combinationally. On out_valid & out_ready that entry's valid is cleared at the edge.
- Simultaneous write and issue: both are performed. in_ready does not account for the slot freed this cycle, so a full bank stalls dispatch for one cycle.
- Flush: clears every valid and is_ref bit and resets age state. It has priority over write, wakeup and issue in the same cycle, and out_valid is still driven that cycle, so the MDU must gate it with flush.
- count = number of valid entries, updated at the edge as +write −issue, or 0 on flush.

## Timing
- Reset (rst low, async): all valid=0, every field reg=0. Outputs out_valid=0, out_*=0, in_ready=1, count=0.
- Write→issuable: an entry written with both operands resolved gives out_valid in the next cycle, i.e. 1-cycle latency.
- CDB→issuable: a broadcast in cycle t makes the entry ready in t+1 (without the bypass macro).
- out_* are stable while out_valid & !out_ready, unless an older entry becomes ready. Oldest-ready is re-evaluated every cycle; a stalled consumer may see a different op.
- Reset released mid-operation: the bank restarts empty; no partial state survives.

## Configuration
- RS_MDU_CDB_BYPASS_EN defined: dispatch-time operands are also compared against the same-cycle CDB. A match is stored resolved, so a write and a broadcast of its tag in cycle t give out_valid at t+1.
- Undefined: that same-cycle broadcast is missed. Dispatch must not present a tag being broadcast in the same cycle (rename stage guarantees this).

## Structure
- Shared package/header (alongside bus.v/rob.v/opgen.v): default widths for OPGEN/EXC/DATA/ROB addr, and the ROB tag extraction macro.
- Sub-module rs_age_matrix (DEPTH×DEPTH bit matrix). Inputs: alloc one-hot, free one-hot, flush, ready vector. Output: one-hot oldest-ready select. Same clk/rst.
- The top level holds the entry arrays, the CDB comparators, the free-slot priority encoder and the output mux.

## Test plan
- Reset: hold rst low mid-traffic → out_valid=0, in_ready=1, count=0 immediately, asynchronously.
- Ordering: write A (rob 3, data 5,7), then B (rob 4, data 1,2), out_ready=0 → out_rob_addr=3 until A issues; next out_rob_addr=4.
- Wakeup: write rob 2 with op1 tag 9 (ref) and op2=0x10. Broadcast cdb_tag[1]=9, data 0xABCD at t → out_valid at t+1 with out_data_1=0xABCD.
- Older waits, younger issues: write X (ref tag 6), then Y (resolved) → Y issues first. Broadcast tag 6 → X issues next.
- Full/simultaneous: fill DEPTH=4 → in_ready=0, count=4. Issue with in_valid held → count=3, and the held write is accepted the following cycle.
- Flush: 3 entries, assert flush together with in_valid → count=0 next cycle, write dropped, out_valid=0.
